// File: rtl/voice_allocator_pkg.sv
// Shared types and helpers for the voice allocator slice: FSM state encoding
// and the index-width function used to size voice addresses.
package voice_allocator_pkg;

    typedef enum logic [1:0] {
        VA_IDLE  = 2'd0,
        VA_SCAN  = 2'd1,
        VA_ISSUE = 2'd2
    } va_state_t;

    // Minimum of one bit so a single-voice build still has an address port.
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters: the selected voice restarts at zero and
// every other voice grows older by one on each note-on issue.
module voice_age_tracker
    import voice_allocator_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int V_WIDTH = clogb2(VOICES),
    parameter int AGE_W   = 4
) (
    input  logic                           CLOCK_25,
    input  logic                           iRST,
    input  logic                           upd,
    input  logic [V_WIDTH-1:0]             sel,
    output logic [VOICES-1:0][AGE_W-1:0]   ages
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    // Age registers: clear on select, saturating increment elsewhere.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            ages <= '0;
        end else if (upd) begin
            for (int v = 0; v < VOICES; v++) begin
                if (V_WIDTH'(v) == sel) begin
                    ages[v] <= {AGE_W{1'b0}};
                end else if (ages[v] != AGE_MAX) begin
                    ages[v] <= ages[v] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Sequential voice scheduler: scans one voice slot per cycle, chooses
// same-key > free > oldest, and issues one registered note event per request.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int V_WIDTH = clogb2(VOICES),
    parameter int AGE_W   = 4
) (
    input  logic                 CLOCK_25,
    input  logic                 iRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_on,
    input  logic [7:0]           req_key,
    input  logic [7:0]           req_vel,
    input  logic [VOICES-1:0]    voice_free,
    output logic                 ev_strb,
    output logic                 note_on,
    output logic [V_WIDTH-1:0]   cur_key_adr,
    output logic [7:0]           cur_key_val,
    output logic [7:0]           cur_vel_on,
    output logic [7:0]           cur_vel_off,
    output logic [VOICES-1:0]    keys_on,
    output logic [V_WIDTH:0]     active_keys,
    output logic                 steal,
    output logic                 off_note_error
);

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    va_state_t                  state_r, state_s;
    logic [V_WIDTH-1:0]         idx_r;
    logic                       on_r;
    logic [6:0]                 key_r;
    logic [7:0]                 vel_r;
    logic [VOICES-1:0]          vfree_r;
    logic [VOICES-1:0][6:0]     key_tab_r;
    logic                       m_found_r, f_found_r;
    logic [V_WIDTH-1:0]         m_idx_r, f_idx_r, o_idx_r;
    logic [AGE_W-1:0]           o_age_r;
    logic [VOICES-1:0][AGE_W-1:0] ages_s;

    logic                       accept_s, last_s, age_upd_s, steal_s;
    logic                       m_found_s, f_found_s;
    logic [V_WIDTH-1:0]         m_idx_s, f_idx_s, o_idx_s, slot_s;
    logic [AGE_W-1:0]           o_age_s;
    logic [VOICES-1:0]          keys_next_s;
    logic [V_WIDTH:0]           pop_s;

    // Next-state logic.
    always_comb begin
        state_s  = state_r;
        accept_s = req_valid && req_ready && (state_r == VA_IDLE);
        last_s   = (state_r == VA_SCAN) && (idx_r == LAST_IDX);
        case (state_r)
            VA_IDLE: begin
                if (accept_s) state_s = VA_SCAN;
                else          state_s = VA_IDLE;
            end
            VA_SCAN: begin
                if (idx_r == LAST_IDX) state_s = VA_ISSUE;
                else                   state_s = VA_SCAN;
            end
            VA_ISSUE: state_s = VA_IDLE;
            default:  state_s = VA_IDLE;
        endcase
    end

    // Scan compare: fold the current slot into the running trackers so the
    // final slot's result is available at the edge that enters ISSUE.
    always_comb begin
        m_found_s = m_found_r;
        m_idx_s   = m_idx_r;
        f_found_s = f_found_r;
        f_idx_s   = f_idx_r;
        o_idx_s   = o_idx_r;
        o_age_s   = o_age_r;
        if (!m_found_r && keys_on[idx_r] && (key_tab_r[idx_r] == key_r)) begin
            m_found_s = 1'b1;
            m_idx_s   = idx_r;
        end else begin
            m_found_s = m_found_r;
        end
        if (!f_found_r && vfree_r[idx_r] && !keys_on[idx_r]) begin
            f_found_s = 1'b1;
            f_idx_s   = idx_r;
        end else begin
            f_found_s = f_found_r;
        end
        if ((idx_r == {V_WIDTH{1'b0}}) || (ages_s[idx_r] > o_age_r)) begin
            o_idx_s = idx_r;
            o_age_s = ages_s[idx_r];
        end else begin
            o_idx_s = o_idx_r;
        end
    end

    // Slot choice and the key-table image after this request completes.
    always_comb begin
        slot_s      = o_idx_s;
        steal_s     = 1'b0;
        keys_next_s = keys_on;
        pop_s       = {(V_WIDTH+1){1'b0}};
        if (m_found_s) begin
            slot_s = m_idx_s;
        end else if (f_found_s) begin
            slot_s = f_idx_s;
        end else begin
            slot_s  = o_idx_s;
            steal_s = keys_on[o_idx_s];
        end
        if (last_s && on_r) begin
            keys_next_s[slot_s] = 1'b1;
        end else if (last_s && m_found_s) begin
            keys_next_s[m_idx_s] = 1'b0;
        end else begin
            keys_next_s = keys_on;
        end
        for (int v = 0; v < VOICES; v++) begin
            pop_s = pop_s + (V_WIDTH+1)'(keys_next_s[v]);
        end
        age_upd_s = last_s && on_r;
    end

    voice_age_tracker #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH),
        .AGE_W   (AGE_W)
    ) u_age (
        .CLOCK_25 (CLOCK_25),
        .iRST     (iRST),
        .upd      (age_upd_s),
        .sel      (slot_s),
        .ages     (ages_s)
    );

    // FSM, request capture, scan trackers, key table and registered outputs.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            state_r        <= VA_IDLE;
            idx_r          <= '0;
            on_r           <= 1'b0;
            key_r          <= 7'd0;
            vel_r          <= 8'd0;
            vfree_r        <= '0;
            key_tab_r      <= '0;
            m_found_r      <= 1'b0;
            f_found_r      <= 1'b0;
            m_idx_r        <= '0;
            f_idx_r        <= '0;
            o_idx_r        <= '0;
            o_age_r        <= '0;
            req_ready      <= 1'b0;
            ev_strb        <= 1'b0;
            note_on        <= 1'b0;
            cur_key_adr    <= '0;
            cur_key_val    <= 8'd0;
            cur_vel_on     <= 8'd0;
            cur_vel_off    <= 8'd0;
            keys_on        <= '0;
            active_keys    <= '0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;
        end else begin
            state_r        <= state_s;
            req_ready      <= (state_s == VA_IDLE);
            keys_on        <= keys_next_s;
            active_keys    <= pop_s;
            ev_strb        <= 1'b0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;
            if (accept_s) begin
                on_r      <= req_on;
                key_r     <= req_key[6:0];
                vel_r     <= req_vel;
                vfree_r   <= voice_free;
                idx_r     <= '0;
                m_found_r <= 1'b0;
                f_found_r <= 1'b0;
            end else if (state_r == VA_SCAN) begin
                idx_r     <= idx_r + V_WIDTH'(1);
                m_found_r <= m_found_s;
                m_idx_r   <= m_idx_s;
                f_found_r <= f_found_s;
                f_idx_r   <= f_idx_s;
                o_idx_r   <= o_idx_s;
                o_age_r   <= o_age_s;
            end
            if (last_s && on_r) begin
                ev_strb           <= 1'b1;
                note_on           <= 1'b1;
                cur_key_adr       <= slot_s;
                cur_key_val       <= {1'b0, key_r};
                cur_vel_on        <= vel_r;
                steal             <= steal_s;
                key_tab_r[slot_s] <= key_r;
            end else if (last_s && m_found_s) begin
                ev_strb     <= 1'b1;
                note_on     <= 1'b0;
                cur_key_adr <= m_idx_s;
                cur_key_val <= {1'b0, key_r};
                cur_vel_off <= vel_r;
            end else if (last_s) begin
                off_note_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table plus randomized
// requests compared against a slot-selection model built from plain arrays.
module tb_voice_allocator;

    localparam int NV = 4;

    logic       CLOCK_25 = 1'b0;
    logic       iRST = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_on = 1'b0;
    logic [7:0] req_key = 8'd0;
    logic [7:0] req_vel = 8'd0;
    logic [3:0] voice_free = 4'hF;
    logic       ev_strb, note_on, steal, off_note_error;
    logic [1:0] cur_key_adr;
    logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;
    logic [3:0] keys_on;
    logic [2:0] active_keys;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit       m_on  [NV];
    int       m_key [NV];
    int       m_age [NV];
    int       m_last_on, m_last_adr, m_last_val, m_vel_on, m_vel_off;

    typedef struct {
        bit       on;
        int       key;
        int       vel;
        bit [3:0] vf;
        bit       tog;
        int       e_adr;
        bit [3:0] e_keys;
        bit       e_steal;
        bit       e_err;
    } vec_t;

    vec_t tbl [16];

    voice_allocator dut (
        .CLOCK_25       (CLOCK_25),
        .iRST           (iRST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_on         (req_on),
        .req_key        (req_key),
        .req_vel        (req_vel),
        .voice_free     (voice_free),
        .ev_strb        (ev_strb),
        .note_on        (note_on),
        .cur_key_adr    (cur_key_adr),
        .cur_key_val    (cur_key_val),
        .cur_vel_on     (cur_vel_on),
        .cur_vel_off    (cur_vel_off),
        .keys_on        (keys_on),
        .active_keys    (active_keys),
        .steal          (steal),
        .off_note_error (off_note_error)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_on[i] = 1'b0; m_key[i] = 0; m_age[i] = 0;
        end
        m_last_on = 0; m_last_adr = 0; m_last_val = 0; m_vel_on = 0; m_vel_off = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ev"},   int'(ev_strb), 0);
        chk({tag, "_keys"}, int'(keys_on), 0);
        chk({tag, "_act"},  int'(active_keys), 0);
        chk({tag, "_fld"},  int'({note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}), 0);
        chk({tag, "_flag"}, int'({steal, off_note_error, req_ready}), 0);
    endtask

    task automatic run_req(input bit on, input int key, input int vel, input bit [3:0] vf,
                           input bit tog, output int c_adr, output int c_keys,
                           output int c_steal, output int c_err);
        int n, mk, match, free, old, slot, e_ev, e_err, e_steal, cnt;
        bit got;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        chk("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1; req_on = on; req_key = 8'(key); req_vel = 8'(vel); voice_free = vf;
        tick();
        req_valid = 1'b0; req_key = 8'($urandom); req_vel = 8'($urandom); req_on = ~on;

        // model: pick slot from specification rules
        mk = key & 127; match = -1; free = -1; old = 0;
        for (int i = 0; i < NV; i++) begin
            if (match < 0 && m_on[i] && m_key[i] == mk) match = i;
            if (free < 0 && vf[i] && !m_on[i]) free = i;
            if (m_age[i] > m_age[old]) old = i;
        end
        e_ev = 0; e_err = 0; e_steal = 0;
        if (on) begin
            slot = (match >= 0) ? match : ((free >= 0) ? free : old);
            e_steal = (match < 0 && free < 0 && m_on[slot]) ? 1 : 0;
            m_on[slot] = 1'b1; m_key[slot] = mk;
            for (int i = 0; i < NV; i++)
                m_age[i] = (i == slot) ? 0 : ((m_age[i] + 1 > 15) ? 15 : m_age[i] + 1);
            m_last_on = 1; m_last_adr = slot; m_last_val = mk; m_vel_on = vel; e_ev = 1;
        end else if (match >= 0) begin
            m_on[match] = 1'b0;
            m_last_on = 0; m_last_adr = match; m_last_val = mk; m_vel_off = vel; e_ev = 1;
        end else begin
            e_err = 1;
        end

        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            if (tog) voice_free = ~voice_free;
            tick(); n++;
            if (ev_strb || off_note_error) got = 1'b1;
        end
        chk("latency", n, NV);
        chk("ev_strb", int'(ev_strb), e_ev);
        chk("off_note_error", int'(off_note_error), e_err);
        chk("steal", int'(steal), e_steal);
        chk("note_on", int'(note_on), m_last_on);
        chk("cur_key_adr", int'(cur_key_adr), m_last_adr);
        chk("cur_key_val", int'(cur_key_val), m_last_val);
        chk("cur_vel_on", int'(cur_vel_on), m_vel_on);
        chk("cur_vel_off", int'(cur_vel_off), m_vel_off);
        cnt = 0; c_keys = 0;
        for (int i = 0; i < NV; i++) begin
            c_keys = c_keys | (int'(m_on[i]) << i);
            cnt += int'(m_on[i]);
        end
        chk("keys_on", int'(keys_on), c_keys);
        chk("active_keys", int'(active_keys), cnt);
        c_adr = int'(cur_key_adr); c_keys = int'(keys_on);
        c_steal = int'(steal); c_err = int'(off_note_error);
        tick();
        chk("pulse_clear", int'({ev_strb, steal, off_note_error}), 0);
        voice_free = vf;
    endtask

    initial begin
        int a, k, s, e, n;
        bit on;
        tbl[0]  = '{1'b1, 60, 100, 4'hF, 1'b0, 0, 4'b0001, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 60,  90, 4'hF, 1'b0, 0, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 61,  10, 4'hF, 1'b0, 0, 4'b0001, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 60,  40, 4'hF, 1'b0, 0, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 60,  70, 4'hF, 1'b0, 0, 4'b0001, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 62,  71, 4'hF, 1'b0, 1, 4'b0011, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 64,  72, 4'hF, 1'b0, 2, 4'b0111, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 67,  73, 4'hF, 1'b0, 3, 4'b1111, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 72,  74, 4'hF, 1'b0, 0, 4'b1111, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 72,  20, 4'hF, 1'b0, 0, 4'b1110, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 62,  21, 4'hF, 1'b0, 1, 4'b1100, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 64,  22, 4'hF, 1'b0, 2, 4'b1000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 67,  23, 4'hF, 1'b0, 3, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 50,  55, 4'hA, 1'b0, 1, 4'b0010, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 50,  56, 4'hA, 1'b0, 1, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 50,  57, 4'hA, 1'b1, 1, 4'b0010, 1'b0, 1'b0};

        model_reset();
        iRST = 1'b1;
        tick(); tick();
        chk_all_zero("reset");
        iRST = 1'b0;
        tick();
        chk("ready_after_reset", int'(req_ready), 1);

        for (int i = 0; i < 16; i++) begin
            run_req(tbl[i].on, tbl[i].key, tbl[i].vel, tbl[i].vf, tbl[i].tog, a, k, s, e);
            chk($sformatf("tbl%0d_adr", i), a, tbl[i].e_adr);
            chk($sformatf("tbl%0d_keys", i), k, int'(tbl[i].e_keys));
            chk($sformatf("tbl%0d_steal", i), s, int'(tbl[i].e_steal));
            chk($sformatf("tbl%0d_err", i), e, int'(tbl[i].e_err));
        end

        // reset in the middle of a scan aborts the request
        req_valid = 1'b1; req_on = 1'b1; req_key = 8'd33; req_vel = 8'd99;
        tick();
        req_valid = 1'b0;
        tick();
        iRST = 1'b1;
        tick();
        chk_all_zero("midscan_reset");
        tick();
        iRST = 1'b0;
        model_reset();
        tick();
        chk("ready_after_abort", int'(req_ready), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(ev_strb) + int'(off_note_error);
            tick();
        end
        chk("no_event_after_abort", n, 0);

        for (int i = 0; i < 60; i++) begin
            on = ($urandom_range(0, 9) < 6);
            run_req(on, (60 + $urandom_range(0, 5)) | ($urandom_range(0, 1) ? 128 : 0),
                    $urandom_range(0, 255), 4'($urandom), 1'($urandom), a, k, s, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
